// File: rtl/piso_stream.sv
// ============================================================================
//  Module   : piso_stream
//  Brief    : Parallel-in/serial-out shifter with valid/ready load, one-word
//             holding buffer for gapless frames, and frame first/last markers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_stream #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("piso_stream: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               ready_q, ready_d;

    logic               w_accept;
    logic               w_consume;
    logic               w_last;
    logic               w_direct_load;
    logic [WIDTH-1:0]   w_shifted;

    assign w_accept      = pi_valid & ready_q;
    assign w_consume     = (state_q == S_SHIFT) & shift_en;
    assign w_last        = (cnt_q == C_LAST);
    // A word arriving exactly as the last bit leaves bypasses the holding buffer.
    assign w_direct_load = w_consume & w_last & ~hold_full_q & w_accept;
    assign w_shifted     = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    shreg_d = pi;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_accept && !w_direct_load) begin
                    hold_d      = pi;
                    hold_full_d = 1'b1;
                end
                if (w_consume) begin
                    if (!w_last) begin
                        shreg_d = w_shifted;
                        cnt_d   = cnt_q + CW'(1);
                    end else if (hold_full_q) begin
                        shreg_d     = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else if (w_accept) begin
                        shreg_d = pi;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
        end
    end

    assign pi_ready = ready_q;
    assign so_valid = (state_q == S_SHIFT);
    assign so       = so_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;
    assign so_first = so_valid & (cnt_q == '0);
    assign so_last  = so_valid & w_last;
    assign busy     = so_valid | hold_full_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_stream.sv
// ============================================================================
//  Module   : tb_piso_stream
//  Brief    : Randomised and directed bench for piso_stream; two instances
//             (8-bit LSB-first, 4-bit MSB-first) against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_stream;

    logic       clk;
    logic       rst;
    logic [7:0] pi_s;
    logic       pi_valid;
    logic       shift_en;

    logic       rdy8, so8, sov8, sof8, sol8, busy8;
    logic       rdy4, so4, sov4, sof4, sol4, busy4;

    int n_chk;
    int n_bad;

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi_s),
        .pi_valid (pi_valid),
        .pi_ready (rdy8),
        .shift_en (shift_en),
        .so       (so8),
        .so_valid (sov8),
        .so_first (sof8),
        .so_last  (sol8),
        .busy     (busy8)
    );

    piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi_s[3:0]),
        .pi_valid (pi_valid),
        .pi_ready (rdy4),
        .shift_en (shift_en),
        .so       (so4),
        .so_valid (sov4),
        .so_first (sof4),
        .so_last  (sol4),
        .busy     (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: the word being sent, index of the bit on the line,
    // and the buffered next word. Index 0 = 8-bit LSB-first, 1 = 4-bit MSB-first.
    int         m_w    [2] = '{8, 4};
    int         m_msb  [2] = '{0, 1};
    int         m_act  [2];
    int         m_k    [2];
    int         m_hf   [2];
    int         m_rstl [2];
    logic [7:0] m_cur  [2];
    logic [7:0] m_hold [2];

    logic       collect;
    logic [7:0] seq8;
    logic [3:0] seq4;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        logic [7:0] d;
        int         ready;
        int         acc;
        d     = pi_s & ((8'd1 << m_w[i]) - 8'd1);
        if (m_w[i] == 8) d = pi_s;
        if (rst) begin
            m_act[i] = 0; m_k[i] = 0; m_hf[i] = 0; m_rstl[i] = 1;
            return;
        end
        ready     = (m_rstl[i] == 0 && m_hf[i] == 0) ? 1 : 0;
        m_rstl[i] = 0;
        acc       = (pi_valid && ready != 0) ? 1 : 0;
        if (m_act[i] == 0) begin
            if (acc != 0) begin
                m_cur[i] = d; m_k[i] = 0; m_act[i] = 1; acc = 0;
            end
        end else if (shift_en) begin
            if (m_k[i] < m_w[i] - 1) begin
                m_k[i]++;
            end else if (m_hf[i] != 0) begin
                m_cur[i] = m_hold[i]; m_k[i] = 0; m_hf[i] = 0;
            end else if (acc != 0) begin
                m_cur[i] = d; m_k[i] = 0; acc = 0;
            end else begin
                m_act[i] = 0;
            end
        end
        if (acc != 0) begin
            m_hold[i] = d; m_hf[i] = 1;
        end
    endtask

    function automatic logic exp_bit(input int i);
        if (m_act[i] == 0) return 1'b0;
        return (m_msb[i] != 0) ? m_cur[i][m_w[i]-1-m_k[i]] : m_cur[i][m_k[i]];
    endfunction

    task automatic check_all();
        logic a8, a4;
        a8 = (m_act[0] != 0);
        a4 = (m_act[1] != 0);
        check_eq("so8",       {31'd0, so8},   {31'd0, exp_bit(0)});
        check_eq("so_valid8", {31'd0, sov8},  {31'd0, a8});
        check_eq("so_first8", {31'd0, sof8},  {31'd0, a8 && m_k[0] == 0});
        check_eq("so_last8",  {31'd0, sol8},  {31'd0, a8 && m_k[0] == 7});
        check_eq("busy8",     {31'd0, busy8}, {31'd0, a8 || m_hf[0] != 0});
        check_eq("ready8",    {31'd0, rdy8},  {31'd0, m_rstl[0] == 0 && m_hf[0] == 0});
        check_eq("so4",       {31'd0, so4},   {31'd0, exp_bit(1)});
        check_eq("so_valid4", {31'd0, sov4},  {31'd0, a4});
        check_eq("so_first4", {31'd0, sof4},  {31'd0, a4 && m_k[1] == 0});
        check_eq("so_last4",  {31'd0, sol4},  {31'd0, a4 && m_k[1] == 3});
        check_eq("busy4",     {31'd0, busy4}, {31'd0, a4 || m_hf[1] != 0});
        check_eq("ready4",    {31'd0, rdy4},  {31'd0, m_rstl[1] == 0 && m_hf[1] == 0});
        if (collect) begin
            if (sov8) seq8 = {seq8[6:0], so8};
            if (sov4) seq4 = {seq4[2:0], so4};
        end
    endtask

    // Called at a negedge: drive inputs, advance the model over the coming
    // posedge, then check at the following negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic se, input logic r);
        pi_valid = v;
        pi_s     = d;
        shift_en = se;
        rst      = r;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        collect = 1'b0;
        seq8 = '0;
        seq4 = '0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_k[i] = 0; m_hf[i] = 0; m_rstl[i] = 1;
            m_cur[i] = '0; m_hold[i] = '0;
        end
        rst = 1'b1; pi_valid = 1'b0; pi_s = '0; shift_en = 1'b0;
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Single word, continuous shifting; captured order checked explicitly.
        collect = 1'b1;
        step(1'b1, 8'hAD, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 8'h00, 1'b1, 1'b0);
        collect = 1'b0;
        check_eq("order_lsb8", {24'd0, seq8}, 32'h000000B5);
        check_eq("order_msb4", {28'd0, seq4}, 32'h0000000D);

        // Back-to-back words: second goes to the holding buffer.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Paced output: shift_en alternating.
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'h00, (c % 2) == 0, 1'b0);

        // Reset mid-frame with a word held.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Direct load on the edge consuming the last bit of the 8-bit frame.
        step(1'b1, 8'h7E, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h81, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0,
                 ($urandom % 250) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
